msrh_stq_commit_pipe: RTL and testbench

//  Drain pipeline for committed stores. Picks the oldest STQ entry in STQ_COMMIT, probes L1D (SQ0),

---
 rtl/msrh_lsu_pkg.sv | 36 +++
 rtl/msrh_oldest_sel.sv | 30 +++
 rtl/msrh_stq_commit_pipe.sv | 135 +++++++++++++
 tb/tb_msrh_stq_commit_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/msrh_lsu_pkg.sv
// Shared types and helpers for the LSU store-commit drain pipeline.
package msrh_lsu_pkg;

   localparam int STQ_SIZE  = 16;
   localparam int PADDR_W   = 56;
   localparam int DATA_W    = 64;
   localparam int LINE_W    = 6;
   localparam int LRQ_SIZE  = 8;
   localparam int STQ_IDX_W = $clog2(STQ_SIZE);

   typedef struct packed {
      logic                 valid;
      logic [STQ_IDX_W-1:0] idx;
      logic [PADDR_W-1:0]   paddr;
      logic [DATA_W-1:0]    data;
      logic [1:0]           size;
   } sq_pipe_t;

   // Wide form of the byte-enable; anything above bit 7 means the access crosses the 8-byte word.
   function automatic logic [15:0] gen_st_be_wide(input logic [1:0] size, input logic [2:0] ofs);
      return ((16'd1 << (4'd1 << size)) - 16'd1) << ofs;
   endfunction

   function automatic logic [7:0] gen_st_be(input logic [1:0] size, input logic [2:0] ofs);
      logic [15:0] be_w;
      be_w = gen_st_be_wide(size, ofs);
      return be_w[7:0];
   endfunction

   function automatic logic st_be_overflow(input logic [1:0] size, input logic [2:0] ofs);
      logic [15:0] be_w;
      be_w = gen_st_be_wide(size, ofs);
      return |be_w[15:8];
   endfunction

endpackage

// File: rtl/msrh_oldest_sel.sv
// Rotate-from-head priority pick: first requester at or after head_i (with wrap), one-hot out.
module msrh_oldest_sel #(
   parameter int N     = 16,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [IDX_W-1:0] head_i,
   input  logic [N-1:0]     req_i,
   output logic             vld_o,
   output logic [N-1:0]     oh_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [IDX_W-1:0] pos;

   always_comb begin
      vld_o = 1'b0;
      oh_o  = '0;
      idx_o = '0;
      pos   = '0;
      for (int i = 0; i < N; i++) begin
         pos = head_i + IDX_W'(i);
         if (!vld_o && req_i[pos]) begin
            vld_o      = 1'b1;
            oh_o[pos]  = 1'b1;
            idx_o      = pos;
         end
      end
   end

endmodule

// File: rtl/msrh_stq_commit_pipe.sv
// Committed-store drain pipe: SQ0 oldest pick + L1D probe, SQ1 hit/miss/replay, SQ2 L1D write.
module msrh_stq_commit_pipe
   import msrh_lsu_pkg::*;
#(
   parameter int STQ_SIZE = msrh_lsu_pkg::STQ_SIZE,
   parameter int PADDR_W  = msrh_lsu_pkg::PADDR_W,
   parameter int DATA_W   = msrh_lsu_pkg::DATA_W,
   parameter int LINE_W   = msrh_lsu_pkg::LINE_W,
   parameter int LRQ_SIZE = msrh_lsu_pkg::LRQ_SIZE
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic [$clog2(STQ_SIZE)-1:0] i_stq_head_idx,
   input  logic [STQ_SIZE-1:0]         i_entry_commit,
   input  logic [PADDR_W-1:0]          i_entry_paddr [STQ_SIZE],
   input  logic [DATA_W-1:0]           i_entry_data  [STQ_SIZE],
   input  logic [1:0]                  i_entry_size  [STQ_SIZE],
   output logic [STQ_SIZE-1:0]         o_sq_op_accept,
   output logic [STQ_SIZE-1:0]         o_sq_l1d_rd_miss,
   output logic [STQ_SIZE-1:0]         o_sq_l1d_rd_conflict,
   output logic                        o_sq_lrq_conflict,
   output logic [LRQ_SIZE-1:0]         o_sq_lrq_index_oh,
   output logic [STQ_SIZE-1:0]         o_sq_l1d_wr_conflict,
   output logic                        o_l1d_rd_req,
   output logic [PADDR_W-1:0]          o_l1d_rd_paddr,
   input  logic                        i_l1d_rd_gnt,
   input  logic                        i_l1d_rd_hit,
   output logic                        o_lrq_req,
   output logic [PADDR_W-1:0]          o_lrq_paddr,
   input  logic                        i_lrq_full,
   input  logic                        i_lrq_conflict,
   input  logic [LRQ_SIZE-1:0]         i_lrq_index_oh,
   output logic                        o_l1d_wr_req,
   output logic [PADDR_W-1:0]          o_l1d_wr_paddr,
   output logic [DATA_W-1:0]           o_l1d_wr_data,
   output logic [DATA_W/8-1:0]         o_l1d_wr_be,
   input  logic                        i_l1d_wr_conflict
);

   localparam int IDX_W = $clog2(STQ_SIZE);

   function automatic logic [STQ_SIZE-1:0] idx_oh(input logic [IDX_W-1:0] idx);
      return STQ_SIZE'(1) << idx;
   endfunction

   sq_pipe_t sq1_q, sq1_d;
   sq_pipe_t sq2_q, sq2_d;
   logic     sq1_gnt_q;

   logic                 cand_vld;
   logic [STQ_SIZE-1:0]  cand_oh;
   logic [IDX_W-1:0]     cand_idx;
   logic [PADDR_W-1:0]   cand_paddr;
   logic                 line_busy_sq1, line_busy_sq2, issue;
   logic                 sq1_replay, sq1_miss, sq1_hit;

   // SQ0: strict oldest-first pick; a line clash holds the pipe rather than skipping ahead
   msrh_oldest_sel #(.N(STQ_SIZE), .IDX_W(IDX_W)) u_sel (
      .head_i (i_stq_head_idx),
      .req_i  (i_entry_commit),
      .vld_o  (cand_vld),
      .oh_o   (cand_oh),
      .idx_o  (cand_idx)
   );

   assign cand_paddr    = i_entry_paddr[cand_idx];
   assign line_busy_sq1 = sq1_q.valid && (sq1_q.paddr[PADDR_W-1:LINE_W] == cand_paddr[PADDR_W-1:LINE_W]);
   assign line_busy_sq2 = sq2_q.valid && (sq2_q.paddr[PADDR_W-1:LINE_W] == cand_paddr[PADDR_W-1:LINE_W]);
   assign issue         = i_reset_n && cand_vld && !line_busy_sq1 && !line_busy_sq2;

   assign o_sq_op_accept = issue ? cand_oh : '0;
   assign o_l1d_rd_req   = issue;
   assign o_l1d_rd_paddr = issue ? cand_paddr : '0;

   always_comb begin
      sq1_d       = '0;
      sq1_d.valid = issue;
      sq1_d.idx   = cand_idx;
      sq1_d.paddr = cand_paddr;
      sq1_d.data  = i_entry_data[cand_idx];
      sq1_d.size  = i_entry_size[cand_idx];
   end

   // SQ1: a full LRQ only matters when the probe actually missed
   assign sq1_replay = sq1_q.valid && (!sq1_gnt_q || (!i_l1d_rd_hit && i_lrq_full));
   assign sq1_miss   = sq1_q.valid && sq1_gnt_q && !i_l1d_rd_hit && !i_lrq_full;
   assign sq1_hit    = sq1_q.valid && sq1_gnt_q && i_l1d_rd_hit;

   assign o_sq_l1d_rd_conflict = sq1_replay ? idx_oh(sq1_q.idx) : '0;
   assign o_sq_l1d_rd_miss     = sq1_miss ? idx_oh(sq1_q.idx) : '0;
   assign o_lrq_req            = sq1_miss;
   assign o_lrq_paddr          = sq1_miss ? sq1_q.paddr : '0;
   assign o_sq_lrq_conflict    = sq1_miss && i_lrq_conflict;
   assign o_sq_lrq_index_oh    = (sq1_miss && i_lrq_conflict) ? i_lrq_index_oh : '0;

   always_comb begin
      sq2_d       = sq1_q;
      sq2_d.valid = sq1_hit;
   end

   // SQ2: align data and byte enables to the 8-byte word
   assign o_l1d_wr_req         = sq2_q.valid;
   assign o_l1d_wr_paddr       = sq2_q.valid ? sq2_q.paddr : '0;
   assign o_l1d_wr_data        = sq2_q.valid ? (sq2_q.data << {sq2_q.paddr[2:0], 3'b000}) : '0;
   assign o_l1d_wr_be          = sq2_q.valid ? gen_st_be(sq2_q.size, sq2_q.paddr[2:0]) : '0;
   assign o_sq_l1d_wr_conflict = (sq2_q.valid && i_l1d_wr_conflict) ? idx_oh(sq2_q.idx) : '0;

   // Only the valids are reset; payload is don't-care while its valid is low
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sq1_q.valid <= 1'b0;
         sq2_q.valid <= 1'b0;
      end else begin
         sq1_q     <= sq1_d;
         sq1_gnt_q <= i_l1d_rd_gnt;
         sq2_q     <= sq2_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset_n) begin
         assert ($onehot0(o_sq_op_accept))
            else $error("sq_op_accept not one-hot: %h", o_sq_op_accept);
         assert ($onehot0(o_sq_l1d_rd_miss))
            else $error("sq_l1d_rd_miss not one-hot: %h", o_sq_l1d_rd_miss);
         assert ($onehot0(o_sq_l1d_rd_conflict))
            else $error("sq_l1d_rd_conflict not one-hot: %h", o_sq_l1d_rd_conflict);
         assert ($onehot0(o_sq_l1d_wr_conflict))
            else $error("sq_l1d_wr_conflict not one-hot: %h", o_sq_l1d_wr_conflict);
         assert (!(sq2_q.valid && st_be_overflow(sq2_q.size, sq2_q.paddr[2:0])))
            else $fatal(1, "misaligned store in SQ2: size=%0d paddr=%h", sq2_q.size, sq2_q.paddr);
      end
   end

endmodule

// File: tb/tb_msrh_stq_commit_pipe.sv
// Directed bench for the store-commit drain pipe with hand-computed expectations.
module tb_msrh_stq_commit_pipe;

   localparam int N  = 16;
   localparam int PW = 56;
   localparam int DW = 64;
   localparam int LQ = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    head;
   logic [N-1:0]  commit;
   logic [PW-1:0] paddr [N];
   logic [DW-1:0] data  [N];
   logic [1:0]    size  [N];
   logic          gnt, hit, lrq_full, lrq_conf, wr_conf_in;
   logic [LQ-1:0] lrq_idx_in;

   logic [N-1:0]  acc, rd_miss, rd_conf, wr_conf;
   logic          lrq_conf_o, rd_req, lrq_req, wr_req;
   logic [LQ-1:0] lrq_idx_o;
   logic [PW-1:0] rd_paddr, lrq_paddr, wr_paddr;
   logic [DW-1:0] wr_data;
   logic [7:0]    be;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   msrh_stq_commit_pipe dut (
      .i_clk                (clk),
      .i_reset_n            (rst_n),
      .i_stq_head_idx       (head),
      .i_entry_commit       (commit),
      .i_entry_paddr        (paddr),
      .i_entry_data         (data),
      .i_entry_size         (size),
      .o_sq_op_accept       (acc),
      .o_sq_l1d_rd_miss     (rd_miss),
      .o_sq_l1d_rd_conflict (rd_conf),
      .o_sq_lrq_conflict    (lrq_conf_o),
      .o_sq_lrq_index_oh    (lrq_idx_o),
      .o_sq_l1d_wr_conflict (wr_conf),
      .o_l1d_rd_req         (rd_req),
      .o_l1d_rd_paddr       (rd_paddr),
      .i_l1d_rd_gnt         (gnt),
      .i_l1d_rd_hit         (hit),
      .o_lrq_req            (lrq_req),
      .o_lrq_paddr          (lrq_paddr),
      .i_lrq_full           (lrq_full),
      .i_lrq_conflict       (lrq_conf),
      .i_lrq_index_oh       (lrq_idx_in),
      .o_l1d_wr_req         (wr_req),
      .o_l1d_wr_paddr       (wr_paddr),
      .o_l1d_wr_data        (wr_data),
      .o_l1d_wr_be          (be),
      .i_l1d_wr_conflict    (wr_conf_in)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp)
         else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      head = '0; commit = '0; gnt = 1'b1; hit = 1'b1;
      lrq_full = 1'b0; lrq_conf = 1'b0; lrq_idx_in = '0; wr_conf_in = 1'b0;
      for (int i = 0; i < N; i++) begin
         paddr[i] = '0; data[i] = '0; size[i] = 2'd3;
      end

      // Reset: nothing issues even with a committed entry present
      step(); step();
      commit[2] = 1'b1;
      settle();
      chk("rst_acc", acc, 0);
      chk("rst_rdreq", rd_req, 0);
      chk("rst_wrreq", wr_req, 0);
      chk("rst_be", be, 0);
      rst_n = 1'b1;

      // Commit {2,5}, head 4: accept 5 then 2, writes in the same order
      head = 4'd4;
      paddr[5] = 56'h5000; size[5] = 2'd3; data[5] = 64'h0102030405060708;
      paddr[2] = 56'h6003; size[2] = 2'd0; data[2] = 64'hAB;
      commit[5] = 1'b1;
      settle();
      chk("A_acc5", acc, 64'h0020);
      chk("A_rdreq", rd_req, 1);
      chk("A_rdpa5", rd_paddr, 64'h5000);
      step(); commit[5] = 1'b0; settle();
      chk("A_acc2", acc, 64'h0004);
      chk("A_rdpa2", rd_paddr, 64'h6003);
      chk("A_nomiss", rd_miss, 0);
      chk("A_noconf", rd_conf, 0);
      step(); commit[2] = 1'b0; settle();
      chk("A_wr5", wr_req, 1);
      chk("A_wrpa5", wr_paddr, 64'h5000);
      chk("A_be5", be, 64'hFF);
      chk("A_wd5", wr_data, 64'h0102030405060708);
      chk("A_idle_acc", acc, 0);
      step(); settle();
      chk("A_wrpa2", wr_paddr, 64'h6003);
      chk("A_be2", be, 64'h08);
      chk("A_wd2", wr_data, 64'hAB000000);
      step(); settle();
      chk("A_wr_idle", wr_req, 0);

      // Entry 3, word store at 0x1000, hit -> write two cycles after accept
      head = 4'd3; paddr[3] = 56'h1000; size[3] = 2'd2; data[3] = 64'h11223344;
      commit[3] = 1'b1;
      settle();
      chk("B_acc3", acc, 64'h0008);
      step(); commit[3] = 1'b0; settle();
      chk("B_rdconf", rd_conf, 0);
      chk("B_rdmiss", rd_miss, 0);
      chk("B_lrqreq", lrq_req, 0);
      chk("B_sq1_nowr", wr_req, 0);
      step(); settle();
      chk("B_wr", wr_req, 1);
      chk("B_be", be, 64'h0F);
      chk("B_wd", wr_data, 64'h11223344);
      chk("B_wrconf", wr_conf, 0);
      step(); settle();

      // Entry 1 halfword at 0x2006 misses and merges into LRQ entry 2
      head = 4'd1; paddr[1] = 56'h2006; size[1] = 2'd1; data[1] = 64'hBEEF;
      commit[1] = 1'b1;
      settle();
      chk("C_acc1", acc, 64'h0002);
      step(); commit[1] = 1'b0;
      hit = 1'b0; lrq_conf = 1'b1; lrq_idx_in = 8'h04;
      settle();
      chk("C_rdmiss", rd_miss, 64'h0002);
      chk("C_lrqreq", lrq_req, 1);
      chk("C_lrqpa", lrq_paddr, 64'h2006);
      chk("C_lrqconf", lrq_conf_o, 1);
      chk("C_lrqidx", lrq_idx_o, 64'h04);
      chk("C_rdconf", rd_conf, 0);
      step(); hit = 1'b1; lrq_conf = 1'b0; lrq_idx_in = '0; settle();
      chk("C_nowr", wr_req, 0);
      chk("C_lrqidx_idle", lrq_idx_o, 0);

      // Same line 0x3000/0x3008: entry 1 waits until entry 0 leaves SQ2
      head = 4'd0;
      paddr[0] = 56'h3000; size[0] = 2'd3; data[0] = 64'hA0;
      paddr[1] = 56'h3008; size[1] = 2'd3; data[1] = 64'hA1;
      commit[0] = 1'b1; commit[1] = 1'b1;
      settle();
      chk("D_acc0", acc, 64'h0001);
      step(); commit[0] = 1'b0; settle();
      chk("D_blk_sq1", acc, 0);
      step(); settle();
      chk("D_blk_sq2", acc, 0);
      chk("D_wrpa0", wr_paddr, 64'h3000);
      step(); settle();
      chk("D_acc1", acc, 64'h0002);
      chk("D_wr_gap", wr_req, 0);
      step(); commit[1] = 1'b0; settle();
      step(); wr_conf_in = 1'b1; settle();
      chk("D_wrpa1", wr_paddr, 64'h3008);
      chk("D_wrconf1", wr_conf, 64'h0002);
      step(); wr_conf_in = 1'b0; settle();

      // Entry 7 without grant -> replay; then miss with LRQ full -> replay, no LRQ request
      head = 4'd7; paddr[7] = 56'h7000; size[7] = 2'd3;
      commit[7] = 1'b1; gnt = 1'b0;
      settle();
      chk("E_acc7", acc, 64'h0080);
      step(); commit[7] = 1'b0; gnt = 1'b1; settle();
      chk("E_rdconf7", rd_conf, 64'h0080);
      chk("E_rdmiss", rd_miss, 0);
      step(); settle();
      chk("E_nowr", wr_req, 0);
      commit[7] = 1'b1;
      settle();
      chk("E_acc7b", acc, 64'h0080);
      step(); commit[7] = 1'b0; hit = 1'b0; lrq_full = 1'b1; settle();
      chk("E_full_conf", rd_conf, 64'h0080);
      chk("E_full_lrqreq", lrq_req, 0);
      chk("E_full_miss", rd_miss, 0);
      step(); hit = 1'b1; lrq_full = 1'b0; settle();
      chk("E_full_nowr", wr_req, 0);

      // Reset with SQ1 and SQ2 occupied
      head = 4'd4;
      paddr[4] = 56'h4000; size[4] = 2'd3;
      paddr[6] = 56'h4100; size[6] = 2'd3;
      commit[4] = 1'b1; commit[6] = 1'b1;
      settle();
      chk("F_acc4", acc, 64'h0010);
      step(); commit[4] = 1'b0; settle();
      chk("F_acc6", acc, 64'h0040);
      step(); commit[6] = 1'b0; settle();
      chk("F_pre_wr", wr_req, 1);
      rst_n = 1'b0;
      settle();
      chk("F_rst_wr", wr_req, 0);
      chk("F_rst_be", be, 0);
      chk("F_rst_rdconf", rd_conf, 0);
      step();
      chk("F_rst_edge_wr", wr_req, 0);
      chk("F_rst_edge_acc", acc, 0);
      rst_n = 1'b1;
      step(); settle();
      chk("F_no_retry", wr_req, 0);
      step(); settle();
      chk("F_no_retry2", wr_req, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
